mix_digest: RTL and testbench

MIX_DIGEST -- requirements
Module: mix_digest

---
 rtl/mix_pkg.sv | 33 +++
 rtl/mix_digest_round.sv | 20 ++
 rtl/mix_digest.sv | 130 +++++++++++++
 tb/tb_mix_digest.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// mix_pkg: shared widths, FSM state encoding and default fold parameters for
// the mix_digest block.
// Ports: none (package only).
package mix_pkg;

  localparam int WORD_W = 32;
  localparam int NWORDS = 8;
  localparam int STATE_W = WORD_W * NWORDS;
  localparam int IDX_W = 3;
  localparam int SEQ_W = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  localparam logic [WORD_W-1:0] DEF_SEED = 32'h0000_0000;
  localparam int unsigned DEF_ROT = 5;
  localparam logic [WORD_W-1:0] DEF_K = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Rotate left by r. The doubled word shifted left leaves the rotated value
  // in the upper half, which also covers r=0 without a shift-by-32 corner.
  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                               input logic [4:0] r);
    logic [2*WORD_W-1:0] t;
    t = {x, x} << r;
    return t[2*WORD_W-1:WORD_W];
  endfunction

endpackage

// File: rtl/mix_digest_round.sv
// mix_digest_round: one combinational fold step, next = (rotl(acc, ROT) ^ word) + K.
// Ports: acc_i (current accumulator), word_i (word being folded in),
//        acc_o (accumulator after this step). Zero latency, no handshake.
module mix_digest_round
  import mix_pkg::*;
#(
  parameter int unsigned ROT = DEF_ROT,
  parameter logic [WORD_W-1:0] K = DEF_K
) (
  input  logic [WORD_W-1:0] acc_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] acc_o
);

  localparam logic [4:0] ROT_AMT = 5'(ROT);

  // XOR must happen before the add; '+' binds tighter than '^' in SV.
  assign acc_o = (rotl32(acc_i, ROT_AMT) ^ word_i) + K;

endmodule

// File: rtl/mix_digest.sv
// mix_digest: captures an 8-word mixer state and folds it word by word into a
// 32-bit digest tagged with a wrapping capture sequence number.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_state (256-bit
//        capture); out_valid/out_ready/out_digest/out_seq (digest handshake).
// Latency: capture at edge N -> out_valid after edge N+8. Output is held while
// out_ready is low; a new capture can overlap the output handshake in HOLD.
module mix_digest
  import mix_pkg::*;
#(
  parameter logic [WORD_W-1:0] SEED = DEF_SEED,
  parameter int unsigned ROT = DEF_ROT,
  parameter logic [WORD_W-1:0] K = DEF_K
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [STATE_W-1:0]  in_state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_digest,
  output logic [SEQ_W-1:0]    out_seq
);

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [SEQ_W-1:0]   out_seq_q, out_seq_d;
  logic [WORD_W-1:0]  out_digest_q, out_digest_d;
  logic [STATE_W-1:0] words_q, words_d;

  logic [WORD_W-1:0]  cur_word;
  logic [WORD_W-1:0]  acc_next;
  logic               in_hs;
  logic               out_hs;

  // Word idx lives at bit offset idx*32.
  assign cur_word = words_q[{idx_q, 5'b0} +: WORD_W];

  mix_digest_round #(
    .ROT (ROT),
    .K   (K)
  ) u_round (
    .acc_i  (acc_q),
    .word_i (cur_word),
    .acc_o  (acc_next)
  );

  assign out_valid  = (state_q == HOLD);
  assign out_digest = out_digest_q;
  assign out_seq    = out_seq_q;
  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;

  // In HOLD the slot frees exactly when the digest leaves, so readiness
  // follows downstream; this lets a capture overlap the output handshake.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      FOLD:    in_ready = 1'b0;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    out_seq_d    = out_seq_q;
    out_digest_d = out_digest_q;
    words_d      = words_q;

    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          state_d = FOLD;
        end
      end
      FOLD: begin
        acc_d = acc_next;
        idx_d = idx_q + 3'd1;
        if (idx_q == LAST_IDX) begin
          out_digest_d = acc_next;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (out_hs) begin
          state_d = in_hs ? FOLD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture is shared by IDLE and HOLD; in FOLD in_ready is low so in_hs
    // cannot fire and the latched words stay frozen.
    if (in_hs) begin
      words_d   = in_state;
      acc_d     = SEED;
      idx_d     = '0;
      out_seq_d = seq_q;
      seq_d     = seq_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      seq_q        <= '0;
      out_seq_q    <= '0;
      out_digest_q <= '0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      out_seq_q    <= out_seq_d;
      out_digest_q <= out_digest_d;
      words_q      <= words_d;
    end
  end

endmodule

// File: tb/tb_mix_digest.sv
// tb_mix_digest: scoreboard bench for mix_digest. Two instances share the
// stimulus: u_dut uses SEED=0, K=0, ROT=5 (hand-checkable digests) and u_dut_b
// uses a non-zero seed, the default K and a different rotation.
module tb_mix_digest;

  localparam logic [31:0] SEED_B = 32'h1234_5678;
  localparam int          ROT_B  = 13;
  localparam logic [31:0] K_B    = 32'h9E37_79B9;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready, in_ready_b;
  logic [255:0] in_state;
  logic         out_valid, out_valid_b;
  logic         out_ready;
  logic [31:0]  out_digest, out_digest_b;
  logic [7:0]   out_seq, out_seq_b;

  mix_digest #(.SEED(32'h0), .ROT(5), .K(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_digest(out_digest), .out_seq(out_seq)
  );

  mix_digest #(.SEED(SEED_B), .ROT(ROT_B), .K(K_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_state(in_state), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_digest(out_digest_b), .out_seq(out_seq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic [7:0]  seq;
    int          cap;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] exp_seq = 8'd0;
  bit         prev_vld = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference fold written independently of the RTL round.
  function automatic logic [31:0] fold(input logic [255:0] st, input logic [31:0] seed,
                                       input int rot, input logic [31:0] k);
    logic [31:0] acc;
    acc = seed;
    for (int i = 0; i < 8; i++) begin
      if (rot % 32 != 0) acc = (acc << (rot % 32)) | (acc >> (32 - rot % 32));
      acc = (acc ^ st[i*32 +: 32]) + k;
    end
    return acc;
  endfunction

  // Monitor: latency on the rising edge of out_valid, contents on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          chk("latency", 32'(cyc - sb[0].cap), 32'd8);
          chk("b_valid_match", {31'd0, out_valid_b}, 32'd1);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("digest_a", out_digest, e.da);
        chk("digest_b", out_digest_b, e.db);
        chk("seq_a", {24'd0, out_seq}, {24'd0, e.seq});
        chk("seq_b", {24'd0, out_seq_b}, {24'd0, e.seq});
      end
      prev_vld = out_valid;
    end else begin
      prev_vld = 1'b0;
    end
  end

  // Offers st; returns after the capturing edge. keep leaves in_valid high.
  task automatic send(input logic [255:0] st, input logic [31:0] ea,
                      input bit keep, output int cap);
    exp_t e;
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_state = st;
    budget = 40;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    cap = -1;
    if (!in_ready) begin
      chk("capture_timeout", 32'd0, 32'd1);
    end else begin
      cap = cyc + 1;
      e.da = ea;
      e.db = fold(st, SEED_B, ROT_B, K_B);
      e.seq = exp_seq;
      e.cap = cap;
      sb.push_back(e);
      exp_seq = exp_seq + 8'd1;
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_state = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_out_valid();
    int budget;
    budget = 30;
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_seq", {24'd0, out_seq}, 32'd0);
    chk("rst_out_digest", out_digest, 32'd0);
    sb.delete();
    exp_seq = 8'd0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] v;
    logic [31:0]  d0;
    int           cap, last_cap;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_state = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_seq", {24'd0, out_seq}, 32'd0);
    chk("reset_out_digest", out_digest, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed digests for SEED=0, K=0, ROT=5.
    send(256'd0, 32'h0000_0000, 1'b0, cap);
    drain();
    v = '0; v[31:0] = 32'h1;
    send(v, 32'h0000_0008, 1'b0, cap);
    drain();
    v = '0; v[255:224] = 32'hFFFF_FFFF;
    send(v, 32'hFFFF_FFFF, 1'b0, cap);
    drain();
    v = '0; v[31:0] = 32'h1; v[255:224] = 32'h1;
    send(v, 32'h0000_0009, 1'b0, cap);
    drain();
    v = '0; v[223:192] = 32'h1;
    send(v, 32'h0000_0020, 1'b0, cap);
    drain();
    for (int i = 0; i < 3; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send(v, fold(v, 32'h0, 5, 32'h0), 1'b0, cap);
      drain();
    end

    // Backpressure: digest held, in_ready low, then a single handshake.
    out_ready = 1'b0;
    v = {8{32'hA5A5_0F0F}};
    send(v, fold(v, 32'h0, 5, 32'h0), 1'b0, cap);
    wait_out_valid();
    d0 = out_digest;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_digest_stable", out_digest, d0);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Reset four edges into FOLD, then a clean capture starting at seq 0.
    v = {8{32'h1357_9BDF}};
    send(v, fold(v, 32'h0, 5, 32'h0), 1'b0, cap);
    repeat (3) @(posedge clk);
    pulse_reset();
    v = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    send(v, fold(v, 32'h0, 5, 32'h0), 1'b0, cap);
    drain();

    // Reset while holding a digest: out_valid must drop at once and the
    // discarded digest must never be handed off.
    out_ready = 1'b0;
    send({8{32'hDEAD_BEEF}}, fold({8{32'hDEAD_BEEF}}, 32'h0, 5, 32'h0), 1'b0, cap);
    wait_out_valid();
    @(posedge clk);
    pulse_reset();
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_output_after_reset", {31'd0, out_valid}, 32'd0);

    // Back-to-back captures through the sequence wrap.
    last_cap = -1;
    for (int i = 0; i < 260; i++) begin
      v = {32'(i * 7), 32'(i ^ 32'h55), 32'(i << 3), 32'hC0DE_0000 + 32'(i),
           32'(i * i), ~32'(i), 32'(i + 1), 32'(i)};
      send(v, fold(v, 32'h0, 5, 32'h0), 1'b1, cap);
      if (last_cap >= 0) chk("b2b_spacing", 32'(cap - last_cap), 32'd9);
      last_cap = cap;
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
